// File: rtl/sequence_blinker_if.sv
// sequence_blinker_if: controller handshake, sequence-memory read port and LED drive.
// on_blinker/level/mem_data flow into the blinker; mem_addr/leds/blinker_done flow out.
interface sequence_blinker_if;
  logic       on_blinker;
  logic [3:0] level;
  logic [3:0] mem_addr;
  logic [1:0] mem_data;
  logic [3:0] leds;
  logic       blinker_done;

  modport master (
    output on_blinker,
    output level,
    output mem_data,
    input  mem_addr,
    input  leds,
    input  blinker_done
  );

  modport slave (
    input  on_blinker,
    input  level,
    input  mem_data,
    output mem_addr,
    output leds,
    output blinker_done
  );
endinterface

// File: rtl/sequence_blinker.sv
// sequence_blinker: plays the first min(level,MAX_LEVEL) colours of the sequence memory on
// one-hot LEDs. Ports: clk, reset (async active-low), bus (slave). Option: SEQ_BLINKER_LEAD_IN_EN.
module sequence_blinker #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int MAX_LEVEL  = 10
) (
  input  logic              clk,
  input  logic              reset,
  sequence_blinker_if.slave bus
);

  localparam int MAXC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
  localparam logic [3:0]    MAX_LEN  = 4'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ON,
    S_OFF,
    S_DONE
`ifdef SEQ_BLINKER_LEAD_IN_EN
    ,
    S_LEADIN,
    S_LEADGAP
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    addr_q, addr_d;
  logic [3:0]    leds_q, leds_d;
  logic          done_q, done_d;

  logic          cnt_zero;
  logic [CW-1:0] cnt_dec;
  logic [3:0]    lvl_cap;
  logic          more;
  logic          active;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = cnt_zero ? cnt_q : cnt_q - 1'b1;
  assign lvl_cap  = (bus.level > MAX_LEN) ? MAX_LEN : bus.level;
  assign more     = ({1'b0, idx_q} + 5'd1) < {1'b0, len_q};

  always_comb begin
    active = 1'b0;
    unique case (state_q)
      S_FETCH, S_LOAD, S_ON, S_OFF: active = 1'b1;
`ifdef SEQ_BLINKER_LEAD_IN_EN
      S_LEADIN, S_LEADGAP:          active = 1'b1;
`endif
      default:                      active = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    leds_d  = leds_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        leds_d = 4'b0000;
        if (bus.on_blinker) begin
          len_d  = lvl_cap;
          idx_d  = 4'd0;
          addr_d = 4'd0;
`ifdef SEQ_BLINKER_LEAD_IN_EN
          leds_d  = 4'b1111;
          cnt_d   = ON_LOAD;
          state_d = S_LEADIN;
`else
          state_d = (lvl_cap == 4'd0) ? S_DONE : S_FETCH;
`endif
        end
      end
`ifdef SEQ_BLINKER_LEAD_IN_EN
      S_LEADIN: begin
        cnt_d = cnt_dec;
        if (cnt_zero) begin
          leds_d  = 4'b0000;
          cnt_d   = OFF_LOAD;
          state_d = S_LEADGAP;
        end
      end
      S_LEADGAP: begin
        cnt_d = cnt_dec;
        if (cnt_zero) begin
          state_d = (len_q == 4'd0) ? S_DONE : S_FETCH;
        end
      end
`endif
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        leds_d  = 4'b0001 << bus.mem_data;
        cnt_d   = ON_LOAD;
        state_d = S_ON;
      end
      S_ON: begin
        cnt_d = cnt_dec;
        if (cnt_zero) begin
          leds_d  = 4'b0000;
          cnt_d   = OFF_LOAD;
          state_d = S_OFF;
        end
      end
      S_OFF: begin
        cnt_d = cnt_dec;
        if (cnt_zero) begin
          if (more) begin
            idx_d   = idx_q + 4'd1;
            addr_d  = idx_q + 4'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        leds_d = 4'b0000;
        if (bus.on_blinker) done_d = 1'b1;
        else                state_d = S_IDLE;
      end
      default: begin
        leds_d  = 4'b0000;
        state_d = S_IDLE;
      end
    endcase

    // Controller withdrew the request mid-playback.
    if (active && !bus.on_blinker) begin
      state_d = S_IDLE;
      leds_d  = 4'b0000;
      idx_d   = 4'd0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      len_q   <= 4'd0;
      cnt_q   <= '0;
      addr_q  <= 4'd0;
      leds_q  <= 4'b0000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      leds_q  <= leds_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_addr     = addr_q;
  assign bus.leds         = leds_q;
  assign bus.blinker_done = done_q;

endmodule
